// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and decode helpers for the iterative multiply/divide unit.
//   op_e    : RV32M/RV64M funct3 operation codes
//   state_e : control FSM states
//   is_div / is_rem / signed_a / signed_b : funct3 decode helpers
package mdu_pkg;

  localparam int unsigned FUNCT3_W = 3;

  typedef enum logic [FUNCT3_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [FUNCT3_W-1:0] f);
    return f[2];
  endfunction

  // Among divide ops, REM/REMU return the remainder.
  function automatic logic is_rem(input logic [FUNCT3_W-1:0] f);
    return f[2] & f[1];
  endfunction

  // rs1 is treated as signed.
  function automatic logic signed_a(input logic [FUNCT3_W-1:0] f);
    case (op_e'(f))
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed.
  function automatic logic signed_b(input logic [FUNCT3_W-1:0] f);
    case (op_e'(f))
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: start/done request bus of the multiply/divide unit.
//   master drives start, kill, funct3, a, b; slave returns busy, done, result.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 32
);
  import mdu_pkg::*;

  logic                start;
  logic                kill;
  logic [FUNCT3_W-1:0] funct3;
  logic [XLEN-1:0]     a;
  logic [XLEN-1:0]     b;
  logic                busy;
  logic                done;
  logic [XLEN-1:0]     result;

  modport master (output start, kill, funct3, a, b, input busy, done, result);
  modport slave  (input start, kill, funct3, a, b, output busy, done, result);

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 step over a {hi, lo} register pair.
//   is_div=0 : shift-add multiply; lo holds the multiplier, op the multiplicand.
//   is_div=1 : restoring divide; lo holds the dividend/quotient, hi the
//              partial remainder, op the divisor.
//   Ports: is_div, hi_i, lo_i, op_i in; hi_o, lo_o out.
module mdu_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] op_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN:0]   diff;

  always_comb begin
    addend = lo_i[0] ? op_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    sh     = {hi_i, lo_i[XLEN-1]};
    // Partial remainder < divisor, so diff's MSB is set exactly when sh < op.
    diff   = sh - {1'b0, op_i};
    hi_o   = hi_i;
    lo_o   = lo_i;
    if (is_div) begin
      if (diff[XLEN]) begin
        hi_o = sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M/RV64M multiply/divide unit, UNROLL bits per cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mdu_iter_if.slave (start, kill, funct3, a, b -> busy, done, result)
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic      clk,
  input  logic      reset,
  mdu_iter_if.slave bus
);

  localparam int unsigned ITERS = XLEN / UNROLL;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [FUNCT3_W-1:0] funct3_q, funct3_d;
  logic                a_neg_q, a_neg_d;
  logic                b_neg_q, b_neg_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [XLEN-1:0]     op_q, op_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic            div_op;
  logic [XLEN-1:0] hi_nx, lo_nx;

  assign div_op = is_div(funct3_q);

  // Chain of UNROLL radix-2 steps fed from the hi/lo registers.
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;
    if (i == 0) begin : g_first
      assign hi_in = hi_q;
      assign lo_in = lo_q;
    end else begin : g_next
      assign hi_in = g_step[i-1].hi_out;
      assign lo_in = g_step[i-1].lo_out;
    end
    mdu_step #(.XLEN(XLEN)) u_step (
      .is_div (div_op),
      .hi_i   (hi_in),
      .lo_i   (lo_in),
      .op_i   (op_q),
      .hi_o   (hi_out),
      .lo_o   (lo_out)
    );
  end

  assign hi_nx = g_step[UNROLL-1].hi_out;
  assign lo_nx = g_step[UNROLL-1].lo_out;

  // Sign fix-up and result select for the FIX state.
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, fix_res;

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = (a_neg_q ^ b_neg_q) ? (~prod + PW'(1)) : prod;
    quot_s  = (a_neg_q ^ b_neg_q) ? (~lo_q + XLEN'(1)) : lo_q;
    rem_s   = a_neg_q ? (~hi_q + XLEN'(1)) : hi_q;
    fix_res = rem_s;
    case (op_e'(funct3_q))
      OP_MUL:                      fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[PW-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quot_s;
      default:                     fix_res = rem_s;
    endcase
  end

  // Request decode: operand signs, magnitudes and divide special cases.
  logic            a_neg_c, b_neg_c, div_zero_c, ovf_c;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_neg_c    = signed_a(bus.funct3) & bus.a[XLEN-1];
    b_neg_c    = signed_b(bus.funct3) & bus.b[XLEN-1];
    a_mag      = a_neg_c ? (~bus.a + XLEN'(1)) : bus.a;
    b_mag      = b_neg_c ? (~bus.b + XLEN'(1)) : bus.b;
    div_zero_c = is_div(bus.funct3) && (bus.b == '0);
    ovf_c      = is_div(bus.funct3) && signed_b(bus.funct3) &&
                 (bus.a == MIN_NEG) && (bus.b == '1);
  end

  // Next-state and register update.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.kill) begin
          funct3_d = bus.funct3;
          a_neg_d  = a_neg_c;
          b_neg_d  = b_neg_c;
          if (div_zero_c) begin
            result_d = is_rem(bus.funct3) ? bus.a : '1;
            state_d  = DONE;
          end else if (ovf_c) begin
            result_d = is_rem(bus.funct3) ? '0 : bus.a;
            state_d  = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = is_div(bus.funct3) ? a_mag : b_mag;
            op_d    = is_div(bus.funct3) ? b_mag : a_mag;
            cnt_d   = CNT_W'(ITERS);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          hi_d  = hi_nx;
          lo_d  = lo_nx;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M/RV64M multiply-divide unit with a start/done handshake. Sits beside the integer ALU in the datapath. It executes the eight M-extension operations over several cycles while the controller stalls. It is generalised in operand width (XLEN) and radix (bits retired per cycle), and adds early-out for divide special cases and a kill input for pipeline flushes.

## Interface
- XLEN, 32: operand and result width; 32 or 64.
- UNROLL, 1: quotient/product bits retired per cycle; 1, 2 or 4; must divide XLEN.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- kill  in  1  abort the in-flight operation; takes priority over start.
- funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- busy  out  1  operation in progress (CALC or FIX).
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE + start (no kill): latch funct3, a, b and sign flags, then branch:
  - DIV/DIVU/REM/REMU with b=0, or DIV/REM with a=most-negative and b=-1: go to DONE directly.
  - Otherwise: take magnitudes, clear the accumulator, load the iteration counter with XLEN/UNROLL, go to CALC.
- CALC:
  - Multiply: shift-add over a 2*XLEN product, UNROLL bits per cycle.
  - Divide: restoring shift-subtract, UNROLL quotient bits per cycle.
  - Decrement the counter each cycle; go to FIX when it reaches 0.
- FIX: apply sign correction and select the result, go to DONE.
  - Product negated if the operand signs differ (MUL, MULH); for MULHSU only a's sign counts.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- DONE: done=1 and result registered, back to IDLE. start is ignored while in DONE.
- Special-case results:
  - Divide by zero: quotient all-ones, remainder = a.
  - Overflow: quotient = a, remainder = 0.
- All arithmetic is modulo 2^XLEN or 2^(2XLEN). No exceptions are raised.
- start while busy=1: ignored; no queueing.
- kill in CALC or FIX: IDLE next cycle, no done pulse, result unchanged.
  - kill in IDLE with start: request dropped.
  - kill in DONE: done still pulses.
- reset (any state, including mid-operation): IDLE, busy=0, done=0, result=0, counter=0.

## Timing
- start accepted at edge t (normal path): busy=1 from t+1 through t+XLEN/UNROLL+1; done=1 and result valid in cycle t+XLEN/UNROLL+2; busy=0 in that cycle.
- Latency is XLEN/UNROLL+2: 34 for XLEN=32, UNROLL=1; 18 for UNROLL=2.
- Special-case path: done in cycle t+1; busy stays 0.
- Back-to-back: a start in the cycle after done is accepted. Minimum issue interval is XLEN/UNROLL+3 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package mdu_pkg:
  - typedef enum of funct3 operation codes.
  - state typedef enum (IDLE, CALC, FIX, DONE).
  - helper function is_div(funct3).
- One sub-module, mdu_step: combinational single radix-2 step (add-or-pass for multiply, subtract-or-restore for divide). mdu_iter instantiates it UNROLL times in a generate chain.
- mdu_iter holds the FSM, counter, operand/accumulator registers and sign fix-up.

## Test plan
- XLEN=32, MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after the start edge, busy high for 33 cycles.
- High products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 -> 1.
- Special cases, each with done at t+1 and busy never asserted:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Control events:
  - Second start mid-CALC -> ignored; first result unaffected.
  - kill at cycle 10 of CALC -> busy=0 next cycle, no done, result keeps its prior value.
  - reset at cycle 5 of CALC -> all outputs 0 next cycle.
- UNROLL=2 and XLEN=64 builds:
  - Randomised 1000 operations against a reference model.
  - Latency 18 for UNROLL=2 (XLEN=32) and 66 for XLEN=64 (UNROLL=1).
